// File: rtl/uart_tx_bitstream.sv
// uart_tx_bitstream: serialises one parallel word per valid/ready handshake into an
// asynchronous frame (start, data LSB-first, optional parity, stop bits). The line
// advances exactly one symbol per i_en tick.
//
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   i_en     bit-period tick (one-cycle pulse, may be held high)
//   i_data   word to send, sampled at handshake only
//   i_valid  i_data valid
//   o_ready  block can accept a word (registered, high only in IDLE)
//   o_tx     serial line, idle high (registered)
//   o_busy   frame in progress (registered, always !o_ready)
module uart_tx_bitstream #(
   parameter int unsigned DATA_BITS = 8,
   parameter int unsigned PARITY    = 0,
   parameter int unsigned STOP_BITS = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_en,
   input  logic [DATA_BITS-1:0] i_data,
   input  logic                 i_valid,
   output logic                 o_ready,
   output logic                 o_tx,
   output logic                 o_busy
);

   localparam int unsigned CNT_W = $clog2(DATA_BITS + 1);
   localparam logic HAS_PAR = (PARITY != 0);
   localparam logic PAR_ODD = (PARITY == 2);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ARMED = 3'd1;
   localparam logic [2:0] S_START = 3'd2;
   localparam logic [2:0] S_DATA  = 3'd3;
   localparam logic [2:0] S_PAR   = 3'd4;
   localparam logic [2:0] S_STOP  = 3'd5;

   // Reject illegal frame formats at elaboration
   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx_bitstream: DATA_BITS must be 5..9");
   end
   if (PARITY > 2) begin : g_bad_parity
      $error("uart_tx_bitstream: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_tx_bitstream: STOP_BITS must be 1 or 2");
   end

   logic [2:0]           state_q, state_d;
   logic [DATA_BITS-1:0] sh_q, sh_d;
   logic                 par_q, par_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [1:0]           stop_q, stop_d;
   logic                 tx_d;
   logic                 accept_c;

   assign accept_c = i_valid && o_ready;

   // Next-state and next-line logic; the shift register presents the next data bit at [0]
   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      par_d   = par_q;
      cnt_d   = cnt_q;
      stop_d  = stop_q;
      tx_d    = o_tx;
      case (state_q)
         S_IDLE: begin
            tx_d = 1'b1;
            // A tick coinciding with acceptance is deliberately not consumed
            if (accept_c) begin
               state_d = S_ARMED;
               sh_d    = i_data;
               par_d   = (^i_data) ^ PAR_ODD;
               cnt_d   = '0;
            end
         end
         S_ARMED: begin
            if (i_en) begin
               tx_d    = 1'b0;
               state_d = S_START;
            end
         end
         S_START: begin
            if (i_en) begin
               tx_d    = sh_q[0];
               sh_d    = sh_q >> 1;
               cnt_d   = CNT_W'(1);
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (i_en) begin
               if (cnt_q < CNT_W'(DATA_BITS)) begin
                  tx_d  = sh_q[0];
                  sh_d  = sh_q >> 1;
                  cnt_d = cnt_q + CNT_W'(1);
               end else if (HAS_PAR) begin
                  tx_d    = par_q;
                  state_d = S_PAR;
               end else begin
                  tx_d    = 1'b1;
                  stop_d  = 2'd1;
                  state_d = S_STOP;
               end
            end
         end
         S_PAR: begin
            if (i_en) begin
               tx_d    = 1'b1;
               stop_d  = 2'd1;
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (i_en) begin
               if (stop_q < 2'(STOP_BITS)) begin
                  stop_d = stop_q + 2'd1;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: begin
            tx_d    = 1'b1;
            state_d = S_IDLE;
         end
      endcase
   end

   // State and registered outputs; ready/busy follow the next state so they are exact complements
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         sh_q    <= '0;
         par_q   <= 1'b0;
         cnt_q   <= '0;
         stop_q  <= '0;
         o_tx    <= 1'b1;
         o_ready <= 1'b1;
         o_busy  <= 1'b0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         par_q   <= par_d;
         cnt_q   <= cnt_d;
         stop_q  <= stop_d;
         o_tx    <= tx_d;
         o_ready <= (state_d == S_IDLE);
         o_busy  <= (state_d != S_IDLE);
      end
   end

endmodule

// File: tb/tb_uart_tx_bitstream.sv
// tb_uart_tx_bitstream: drives five frame formats of uart_tx_bitstream and compares
// the line, ready and busy every cycle against a symbol-list model of the frame.
//   unit 0: 8N1   unit 1: 8E2   unit 2: 8O1   unit 3: 5E1   unit 4: 9O2
module tb_uart_tx_bitstream;

   logic       clk = 1'b0;
   logic       rst;
   logic       i_en;
   logic [8:0] data;
   logic [4:0] v_w;
   logic [4:0] tx_w, rdy_w, bsy_w;

   always #5 clk = ~clk;

   uart_tx_bitstream #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
      .clk(clk), .rst(rst), .i_en(i_en), .i_data(data[7:0]), .i_valid(v_w[0]),
      .o_ready(rdy_w[0]), .o_tx(tx_w[0]), .o_busy(bsy_w[0]));
   uart_tx_bitstream #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) u1 (
      .clk(clk), .rst(rst), .i_en(i_en), .i_data(data[7:0]), .i_valid(v_w[1]),
      .o_ready(rdy_w[1]), .o_tx(tx_w[1]), .o_busy(bsy_w[1]));
   uart_tx_bitstream #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u2 (
      .clk(clk), .rst(rst), .i_en(i_en), .i_data(data[7:0]), .i_valid(v_w[2]),
      .o_ready(rdy_w[2]), .o_tx(tx_w[2]), .o_busy(bsy_w[2]));
   uart_tx_bitstream #(.DATA_BITS(5), .PARITY(1), .STOP_BITS(1)) u3 (
      .clk(clk), .rst(rst), .i_en(i_en), .i_data(data[4:0]), .i_valid(v_w[3]),
      .o_ready(rdy_w[3]), .o_tx(tx_w[3]), .o_busy(bsy_w[3]));
   uart_tx_bitstream #(.DATA_BITS(9), .PARITY(2), .STOP_BITS(2)) u4 (
      .clk(clk), .rst(rst), .i_en(i_en), .i_data(data[8:0]), .i_valid(v_w[4]),
      .o_ready(rdy_w[4]), .o_tx(tx_w[4]), .o_busy(bsy_w[4]));

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;
   logic [2:0] sel = 3'd0;

   // Reference model: the frame as a list of symbols, indexed by ticks taken since acceptance
   bit m_active = 1'b0;
   bit m_tx     = 1'b1;
   int m_k      = 0;
   bit m_syms[$];

   function automatic int db_of(input logic [2:0] s);
      case (s)
         3'd3:    return 5;
         3'd4:    return 9;
         default: return 8;
      endcase
   endfunction

   function automatic int par_of(input logic [2:0] s);
      case (s)
         3'd1, 3'd3: return 1;
         3'd2, 3'd4: return 2;
         default:    return 0;
      endcase
   endfunction

   function automatic int sb_of(input logic [2:0] s);
      case (s)
         3'd1, 3'd4: return 2;
         default:    return 1;
      endcase
   endfunction

   function automatic int frame_ticks(input logic [2:0] s);
      return 1 + db_of(s) + ((par_of(s) != 0) ? 1 : 0) + sb_of(s) + 1;
   endfunction

   function automatic bit gen_en(input int mode, input int per);
      if (mode == 1) return 1'b1;
      if (mode == 2) return 1'($urandom % 2);
      return (cyc % per) == 0;
   endfunction

   task automatic build_frame(input logic [8:0] w);
      int ones = 0;
      m_syms.delete();
      m_syms.push_back(1'b0);
      for (int i = 0; i < db_of(sel); i++) begin
         m_syms.push_back(w[i]);
         ones += int'(w[i]);
      end
      if (par_of(sel) == 1) m_syms.push_back(1'((ones % 2)));
      if (par_of(sel) == 2) m_syms.push_back(1'(1 - (ones % 2)));
      for (int i = 0; i < sb_of(sel); i++) m_syms.push_back(1'b1);
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s (unit %0d, cycle %0d): observed %0h expected %0h", tag, sel, cyc, got, exp);
      end
   endtask

   // One clock: drive at the falling edge, advance the model at the rising edge, check at the next falling edge
   task automatic step(input bit en, input bit v, input logic [8:0] d, input bit r);
      i_en = en;
      data = d;
      rst  = r;
      v_w  = '0;
      v_w[sel] = v;
      @(posedge clk);
      if (r) begin
         m_active = 1'b0;
         m_tx     = 1'b1;
      end else if (!m_active) begin
         if (v) begin
            build_frame(d);
            m_active = 1'b1;
            m_k      = 0;
         end
      end else if (en) begin
         m_k++;
         if (m_k <= m_syms.size()) m_tx = m_syms[m_k-1];
         else begin
            m_active = 1'b0;
            m_tx     = 1'b1;
         end
      end
      cyc++;
      @(negedge clk);
      chk("tx",    32'(tx_w[sel]),  32'(m_tx));
      chk("busy",  32'(bsy_w[sel]), 32'(m_active));
      chk("ready", 32'(rdy_w[sel]), 32'(!m_active));
   endtask

   // Present w until accepted (unless a frame is already running), then noise the inputs until done
   task automatic run(input logic [8:0] w, input int mode, input int per);
      bit started   = m_active;
      int pulses    = 0;
      int busy_cyc  = 0;
      bit rdy_prev  = rdy_w[sel];
      bit en;
      bit done      = 1'b0;
      for (int n = 0; n < 400 && !done; n++) begin
         en = gen_en(mode, per);
         if (en && !rdy_prev && started) pulses++;
         if (!started) step(en, 1'b1, w, 1'b0);
         else          step(en, 1'($urandom % 2), 9'($urandom), 1'b0);
         if (m_active) started = 1'b1;
         if (bsy_w[sel] === 1'b1) busy_cyc++;
         rdy_prev = rdy_w[sel];
         if (started && !m_active) done = 1'b1;
      end
      if (!done) chk("timeout_busy", 32'(bsy_w[sel]), 32'd0);
      else begin
         chk("ticks_to_ready", 32'(pulses), 32'(frame_ticks(sel)));
         if (mode == 1) chk("busy_cycles", 32'(busy_cyc), 32'(frame_ticks(sel)));
      end
   endtask

   initial begin
      int acc;
      bit prev;
      bit en;
      rst  = 1'b1;
      i_en = 1'b0;
      data = '0;
      v_w  = '0;

      // Reset state of every unit, with ticks and valid ignored during reset
      step(1'b1, 1'b1, 9'h0A5, 1'b1);
      step(1'b0, 1'b0, 9'h000, 1'b1);
      for (int i = 0; i < 5; i++) begin
         chk("rst_tx",    32'(tx_w[i]),  32'd1);
         chk("rst_ready", 32'(rdy_w[i]), 32'd1);
         chk("rst_busy",  32'(bsy_w[i]), 32'd0);
      end

      // Basic 8N1 with a tick every 4 clocks
      sel = 3'd0; run(9'h0A5, 0, 4);
      // Parity even / odd on 0x07, two stop bits on the even unit
      sel = 3'd1; run(9'h007, 0, 3);
      sel = 3'd2; run(9'h007, 0, 3);
      // Tick held high: one symbol per clock
      sel = 3'd0; run(9'h03C, 1, 1);

      // Acceptance with a coincident tick: that tick is not consumed
      step(1'b1, 1'b1, 9'h05A, 1'b0);
      step(1'b0, 1'b0, 9'h1FF, 1'b0);
      step(1'b0, 1'b1, 9'h000, 1'b0);
      run(9'h000, 0, 3);

      // Back-to-back: valid held high, second word taken in the first idle cycle
      acc  = 0;
      prev = m_active;
      for (int n = 0; n < 300 && !(acc == 2 && !m_active); n++) begin
         en = gen_en(0, 4);
         step(en, acc < 2, (acc == 0) ? 9'h055 : 9'h0AA, 1'b0);
         if (m_active && !prev) acc++;
         prev = m_active;
      end
      chk("b2b_frames", 32'(acc), 32'd2);

      // Reset during data bit 3, then a clean 0xFF frame
      step(1'b0, 1'b1, 9'h0C3, 1'b0);
      for (int n = 0; n < 100 && m_k < 5; n++) step(gen_en(0, 2), 1'b0, 9'h000, 1'b0);
      step(1'b0, 1'b0, 9'h000, 1'b1);
      run(9'h0FF, 0, 2);

      // Random formats, words and tick patterns
      for (int f = 0; f < 30; f++) begin
         sel = 3'($urandom % 5);
         run(9'($urandom), int'($urandom % 3), 2 + int'($urandom % 4));
         if (($urandom % 3) == 0) step(1'b0, 1'b0, 9'h000, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
